// File: rtl/control_pkg.sv
// control_pkg: shared state encoding and datapath select constants for the control unit
package control_pkg;
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_LINK, S_NEXTPC, S_TRAP, S_HALT
    } state_e;
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [1:0] INSEL1_RS1  = 2'd0;
    localparam logic [1:0] INSEL1_PC   = 2'd1;
    localparam logic [1:0] INSEL1_ZERO = 2'd2;
    localparam logic [1:0] INSEL2_RS2  = 2'd0;
    localparam logic [1:0] INSEL2_IMM  = 2'd1;
    localparam logic [1:0] INSEL2_FOUR = 2'd2;
    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_ALU = 1'b1;
    localparam logic RD_ALU = 1'b0;
    localparam logic RD_MEM = 1'b1;
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts cycles a memory request waits for completion and flags the last allowed one
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    input  logic fc,
    output logic expired
);
    localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
    logic [TO_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = start ? '0 : (busy && !fc) ? cnt_q + 1'b1 : cnt_q;
    end
    // kept out of the block above so start (from next state) never feeds back into expired
    assign expired = (MEM_TIMEOUT > 0) && busy && !fc && (cnt_q == LIMIT);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle RV32I sequencer driving datapath strobes, selects, trap and halt
module control_unit
    import control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       invalid_inst,
    input  logic       ialign,
    input  logic       mem_fc,
    input  logic       mem_malign,
    input  logic       opcode_load,
    input  logic       opcode_miscmem,
    input  logic       opcode_opimm,
    input  logic       opcode_auipc,
    input  logic       opcode_store,
    input  logic       opcode_op,
    input  logic       opcode_lui,
    input  logic       opcode_branch,
    input  logic       opcode_jalr,
    input  logic       opcode_jal,
    input  logic       opcode_system,
    input  logic [4:0] aluop_in,
    input  logic       branch_taken,
    output logic       write_pc,
    output logic       write_ir,
    output logic       write_rd,
    output logic       mem_read,
    output logic       mem_write,
    output logic [4:0] alu_op,
    output logic       addr_sel,
    output logic       rd_sel,
    output logic [1:0] alu_insel1,
    output logic [1:0] alu_insel2,
    output logic       trap,
    output logic       halted
);
    state_e state_q, state_d;
    logic br_flag_q, br_flag_d;
    logic expired, wd_start, wd_busy, is_jump, redirect;
    logic [10:0] ops;

    assign ops = {opcode_system, opcode_jal, opcode_jalr, opcode_branch, opcode_lui, opcode_op,
                  opcode_store, opcode_auipc, opcode_opimm, opcode_miscmem, opcode_load};
    assign is_jump = opcode_jal || opcode_jalr;
    assign wd_busy = (state_q == S_FETCH) || (state_q == S_MEM && !mem_malign);
    assign wd_start = (state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM);

    mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_wd (
        .clk(clk), .rst(rst), .start(wd_start), .busy(wd_busy), .fc(mem_fc), .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        br_flag_d = br_flag_q;
        redirect = 1'b0;
        write_pc = 1'b0;
        write_ir = 1'b0;
        write_rd = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        alu_op = ALU_ADD;
        addr_sel = ADDR_PC;
        rd_sel = RD_ALU;
        alu_insel1 = INSEL1_RS1;
        alu_insel2 = INSEL2_RS2;
        trap = 1'b0;
        halted = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                write_ir = mem_fc;
                state_d = mem_fc ? S_DECODE : expired ? S_TRAP : S_FETCH;
            end
            S_DECODE: begin
                state_d = (invalid_inst || !$onehot(ops)) ? S_TRAP :
                          (opcode_load || opcode_store) ? S_MEM :
                          opcode_miscmem ? S_NEXTPC :
                          opcode_system ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                alu_op = (opcode_op || opcode_opimm || opcode_branch) ? aluop_in : ALU_ADD;
                alu_insel1 = opcode_lui ? INSEL1_ZERO :
                             (opcode_auipc || opcode_jal) ? INSEL1_PC : INSEL1_RS1;
                alu_insel2 = (opcode_op || opcode_branch) ? INSEL2_RS2 : INSEL2_IMM;
                write_rd = opcode_op || opcode_opimm || opcode_lui || opcode_auipc;
                br_flag_d = opcode_branch ? branch_taken : br_flag_q;
                state_d = !is_jump ? S_NEXTPC : ialign ? S_TRAP : S_LINK;
            end
            S_MEM: begin
                addr_sel = ADDR_ALU;
                alu_insel2 = INSEL2_IMM;
                mem_read = opcode_load && !mem_malign;
                mem_write = opcode_store && !mem_malign;
                write_rd = opcode_load && !mem_malign && mem_fc;
                rd_sel = (opcode_load && mem_fc) ? RD_MEM : RD_ALU;
                state_d = mem_malign ? S_TRAP : mem_fc ? S_NEXTPC : expired ? S_TRAP : S_MEM;
            end
            S_LINK: begin
                alu_insel1 = INSEL1_PC;
                alu_insel2 = INSEL2_FOUR;
                write_rd = 1'b1;
                state_d = S_NEXTPC;
            end
            S_NEXTPC: begin
                redirect = is_jump || (opcode_branch && br_flag_q);
                alu_insel1 = opcode_jalr ? INSEL1_RS1 : INSEL1_PC;
                alu_insel2 = redirect ? INSEL2_IMM : INSEL2_FOUR;
                write_pc = !(redirect && ialign);
                state_d = (redirect && ialign) ? S_TRAP : S_FETCH;
            end
            S_TRAP: trap = 1'b1;
            S_HALT: halted = 1'b1;
            default: state_d = S_TRAP;
        endcase
        if (rst) begin
            write_pc = 1'b0;
            write_ir = 1'b0;
            write_rd = 1'b0;
            mem_read = 1'b0;
            mem_write = 1'b0;
            alu_op = ALU_ADD;
            addr_sel = ADDR_PC;
            rd_sel = RD_ALU;
            alu_insel1 = INSEL1_RS1;
            alu_insel2 = INSEL2_RS2;
            trap = 1'b0;
            halted = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            br_flag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            br_flag_q <= br_flag_d;
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed per-cycle checks of the control unit sequencing, traps and watchdog
module tb_control_unit;
    localparam logic [10:0] LOAD = 11'h001, MISCMEM = 11'h002, OPIMM = 11'h004, AUIPC = 11'h008;
    localparam logic [10:0] STORE = 11'h010, OP = 11'h020, LUI = 11'h040, BRANCH = 11'h080;
    localparam logic [10:0] JALR = 11'h100, JAL = 11'h200, SYSTEM = 11'h400;

    logic clk, rst, invalid_inst, ialign, mem_fc, mem_malign, branch_taken;
    logic [10:0] ops;
    logic [4:0] aluop_in, alu_op;
    logic write_pc, write_ir, write_rd, mem_read, mem_write, addr_sel, rd_sel, trap, halted;
    logic [1:0] alu_insel1, alu_insel2;
    logic [17:0] obs;
    int vectors = 0;
    int miscompares = 0;

    control_unit #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .invalid_inst(invalid_inst), .ialign(ialign), .mem_fc(mem_fc),
        .mem_malign(mem_malign), .opcode_load(ops[0]), .opcode_miscmem(ops[1]),
        .opcode_opimm(ops[2]), .opcode_auipc(ops[3]), .opcode_store(ops[4]), .opcode_op(ops[5]),
        .opcode_lui(ops[6]), .opcode_branch(ops[7]), .opcode_jalr(ops[8]), .opcode_jal(ops[9]),
        .opcode_system(ops[10]), .aluop_in(aluop_in), .branch_taken(branch_taken),
        .write_pc(write_pc), .write_ir(write_ir), .write_rd(write_rd), .mem_read(mem_read),
        .mem_write(mem_write), .alu_op(alu_op), .addr_sel(addr_sel), .rd_sel(rd_sel),
        .alu_insel1(alu_insel1), .alu_insel2(alu_insel2), .trap(trap), .halted(halted)
    );

    assign obs = {write_pc, write_ir, write_rd, mem_read, mem_write, addr_sel, rd_sel,
                  alu_insel1, alu_insel2, trap, halted, alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {wpc, wir, wrd, mread, mwrite, addr_sel, rd_sel, insel1, insel2, trap, halted, alu_op}
    function automatic logic [17:0] ev(input logic wpc, wir, wrd, mr, mw, as_, rs,
                                       input logic [1:0] i1, i2, input logic tr, hl,
                                       input logic [4:0] op);
        return {wpc, wir, wrd, mr, mw, as_, rs, i1, i2, tr, hl, op};
    endfunction

    localparam logic [17:0] E_IDLE = 18'd0;
    localparam logic [17:0] E_FETCH = 18'b000100_0_00_00_00_00000;
    localparam logic [17:0] E_FETCH_FC = 18'b010100_0_00_00_00_00000;
    localparam logic [17:0] E_TRAP = 18'b000000_0_00_00_10_00000;
    localparam logic [17:0] E_HALT = 18'b000000_0_00_00_01_00000;
    localparam logic [17:0] E_NEXT4 = 18'b100000_0_01_10_00_00000;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        {mem_fc, ialign, branch_taken, mem_malign, invalid_inst} = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        ops = OPIMM;
        aluop_in = 5'd3;
        rst = 1'b1;
        mem_fc = 1'b1;
        tick;
        #4;
        vectors++;
        if (obs !== E_IDLE) begin
            miscompares++;
            $display("FAIL reset outputs got=%h want=%h", obs, E_IDLE);
        end
        tick;
    endtask

    task automatic test_addi;
        logic [3:0] iv [5];
        logic [17:0] e [5];
        ops = OPIMM;
        aluop_in = 5'd3;
        do_reset;
        iv = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        e = '{E_FETCH_FC, E_IDLE, ev(0,0,1,0,0,0,0,2'd0,2'd1,0,0,5'd3), E_NEXT4, E_FETCH};
        for (int i = 0; i < 5; i++) begin
            {mem_fc, ialign, branch_taken, mem_malign} = iv[i];
            #4;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL addi cycle %0d got=%h want=%h", i, obs, e[i]);
            end
            tick;
        end
    endtask

    task automatic test_load_wait;
        logic [3:0] iv [7];
        logic [17:0] e [7];
        ops = LOAD;
        aluop_in = 5'd9;
        do_reset;
        iv = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        e = '{E_FETCH_FC, E_IDLE, ev(0,0,0,1,0,1,0,2'd0,2'd1,0,0,5'd0),
              ev(0,0,0,1,0,1,0,2'd0,2'd1,0,0,5'd0), ev(0,0,1,1,0,1,1,2'd0,2'd1,0,0,5'd0),
              E_NEXT4, E_FETCH};
        for (int i = 0; i < 7; i++) begin
            {mem_fc, ialign, branch_taken, mem_malign} = iv[i];
            #4;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL load cycle %0d got=%h want=%h", i, obs, e[i]);
            end
            tick;
        end
    endtask

    task automatic test_branch;
        logic [3:0] iv [5];
        logic [17:0] e [5];
        for (int b = 1; b >= 0; b--) begin
            ops = BRANCH;
            aluop_in = 5'd8;
            do_reset;
            iv = '{4'b1000, 4'b0000, {2'b00, b[0], 1'b0}, 4'b0000, 4'b0000};
            e = '{E_FETCH_FC, E_IDLE, ev(0,0,0,0,0,0,0,2'd0,2'd0,0,0,5'd8),
                  ev(1,0,0,0,0,0,0,2'd1,b[0] ? 2'd1 : 2'd2,0,0,5'd0), E_FETCH};
            for (int i = 0; i < 5; i++) begin
                {mem_fc, ialign, branch_taken, mem_malign} = iv[i];
                #4;
                vectors++;
                if (obs !== e[i]) begin
                    miscompares++;
                    $display("FAIL branch taken=%0d cycle %0d got=%h want=%h", b, i, obs, e[i]);
                end
                tick;
            end
        end
    endtask

    task automatic test_jumps;
        logic [3:0] iv [6];
        logic [17:0] e [6];
        ops = JAL;
        aluop_in = 5'd5;
        do_reset;
        iv = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        e = '{E_FETCH_FC, E_IDLE, ev(0,0,0,0,0,0,0,2'd1,2'd1,0,0,5'd0),
              ev(0,0,1,0,0,0,0,2'd1,2'd2,0,0,5'd0), ev(1,0,0,0,0,0,0,2'd1,2'd1,0,0,5'd0), E_FETCH};
        for (int i = 0; i < 6; i++) begin
            {mem_fc, ialign, branch_taken, mem_malign} = iv[i];
            #4;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL jal cycle %0d got=%h want=%h", i, obs, e[i]);
            end
            tick;
        end
        ops = JALR;
        do_reset;
        iv = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        e = '{E_FETCH_FC, E_IDLE, ev(0,0,0,0,0,0,0,2'd0,2'd1,0,0,5'd0), E_TRAP, E_TRAP, E_TRAP};
        for (int i = 0; i < 6; i++) begin
            {mem_fc, ialign, branch_taken, mem_malign} = iv[i];
            #4;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL jalr_misaligned cycle %0d got=%h want=%h", i, obs, e[i]);
            end
            tick;
        end
    endtask

    task automatic test_timeout;
        logic [17:0] e [6];
        ops = OPIMM;
        do_reset;
        e = '{E_FETCH, E_FETCH, E_FETCH, E_FETCH, E_TRAP, E_TRAP};
        for (int i = 0; i < 6; i++) begin
            #4;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL timeout cycle %0d got=%h want=%h", i, obs, e[i]);
            end
            tick;
        end
        rst = 1'b1;
        #4;
        vectors++;
        if (obs !== E_IDLE) begin
            miscompares++;
            $display("FAIL timeout_in_reset got=%h want=%h", obs, E_IDLE);
        end
        tick;
        rst = 1'b0;
        #4;
        vectors++;
        if (obs !== E_FETCH) begin
            miscompares++;
            $display("FAIL timeout_after_reset got=%h want=%h", obs, E_FETCH);
        end
        tick;
    endtask

    task automatic test_reset_mid_store;
        logic [3:0] iv [3];
        logic [17:0] e [3];
        ops = STORE;
        do_reset;
        iv = '{4'b1000, 4'b0000, 4'b0000};
        e = '{E_FETCH_FC, E_IDLE, ev(0,0,0,0,1,1,0,2'd0,2'd1,0,0,5'd0)};
        for (int i = 0; i < 3; i++) begin
            {mem_fc, ialign, branch_taken, mem_malign} = iv[i];
            #4;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL store cycle %0d got=%h want=%h", i, obs, e[i]);
            end
            tick;
        end
        rst = 1'b1;
        #4;
        vectors++;
        if (mem_write !== 1'b0) begin
            miscompares++;
            $display("FAIL store_reset mem_write got=%b want=0", mem_write);
        end
        tick;
        rst = 1'b0;
        #4;
        vectors++;
        if (obs !== E_FETCH) begin
            miscompares++;
            $display("FAIL store_after_reset got=%h want=%h", obs, E_FETCH);
        end
        tick;
    endtask

    task automatic test_misc;
        logic [3:0] iv [4];
        logic [17:0] e [4];
        ops = STORE;
        do_reset;
        iv = '{4'b1000, 4'b0000, 4'b0001, 4'b0000};
        e = '{E_FETCH_FC, E_IDLE, ev(0,0,0,0,0,1,0,2'd0,2'd1,0,0,5'd0), E_TRAP};
        for (int i = 0; i < 4; i++) begin
            {mem_fc, ialign, branch_taken, mem_malign} = iv[i];
            #4;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL malign cycle %0d got=%h want=%h", i, obs, e[i]);
            end
            tick;
        end
        ops = MISCMEM;
        do_reset;
        iv = '{4'b1000, 4'b0000, 4'b0000, 4'b0000};
        e = '{E_FETCH_FC, E_IDLE, E_NEXT4, E_FETCH};
        for (int i = 0; i < 4; i++) begin
            {mem_fc, ialign, branch_taken, mem_malign} = iv[i];
            #4;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL fence cycle %0d got=%h want=%h", i, obs, e[i]);
            end
            tick;
        end
    endtask

    task automatic test_decode_faults;
        logic [10:0] sops [4];
        logic sinv [4];
        logic [17:0] send [4];
        logic [17:0] e [4];
        sops = '{OP | OPIMM, OPIMM, SYSTEM, 11'h000};
        sinv = '{1'b0, 1'b1, 1'b0, 1'b0};
        send = '{E_TRAP, E_TRAP, E_HALT, E_TRAP};
        for (int s = 0; s < 4; s++) begin
            ops = sops[s];
            do_reset;
            invalid_inst = sinv[s];
            e = '{E_FETCH_FC, E_IDLE, send[s], send[s]};
            for (int i = 0; i < 4; i++) begin
                mem_fc = (i == 0);
                #4;
                vectors++;
                if (obs !== e[i]) begin
                    miscompares++;
                    $display("FAIL decode case %0d cycle %0d got=%h want=%h", s, i, obs, e[i]);
                end
                tick;
            end
        end
    endtask

    initial begin
        {rst, invalid_inst, ialign, mem_fc, mem_malign, branch_taken} = '0;
        ops = '0;
        aluop_in = '0;
        test_reset;
        test_addi;
        test_load_wait;
        test_branch;
        test_jumps;
        test_timeout;
        test_reset_mid_store;
        test_misc;
        test_decode_faults;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
